// File: rtl/serial_to_parallel_reg_if.sv
// Bit-stream input and word-output handshake bundle for serial_to_parallel_reg.
// master drives the serial stream and consumer ready; slave is the deserializer.
interface serial_to_parallel_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serial_in;
  logic             bit_valid;
  logic             frame_clear;
  logic             data_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic [3:0]       bit_count;

  modport master (
    output serial_in, bit_valid, frame_clear, data_ready,
    input  data_out, data_valid, overrun, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, frame_clear, data_ready,
    output data_out, data_valid, overrun, bit_count
  );
endinterface

// File: rtl/serial_to_parallel_reg.sv
// Serial-to-parallel deserializer: collects WIDTH qualified bits per word and hands each word
// to a one-entry valid/ready output buffer with a sticky overrun flag.
module serial_to_parallel_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                     clk,
  input logic                     resetn,
  serial_to_parallel_reg_if.slave bus
);

  typedef enum logic {StEmpty, StFull} buf_state_e;

  localparam logic [3:0] LastBit = 4'(WIDTH - 1);

  buf_state_e       buf_state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_q;
  logic [3:0]       count_q;
  logic             overrun_q;
  logic             word_done;
  logic             transfer;

  // shifted includes the current bit, so it is also the completed word on the last bit
  always_comb begin
    shifted = shift_q;
    if (LSB_FIRST) begin
      shifted = {bus.serial_in, shift_q[WIDTH-1:1]};
    end else begin
      shifted = {shift_q[WIDTH-2:0], bus.serial_in};
    end
  end

  assign word_done = bus.bit_valid & ~bus.frame_clear & (count_q == LastBit);
  assign transfer  = (buf_state_q == StFull) & bus.data_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_state_q <= StEmpty;
      shift_q     <= '0;
      data_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      // Collector: frame_clear wins over a coincident bit
      if (bus.frame_clear) begin
        count_q <= '0;
        shift_q <= '0;
      end else if (bus.bit_valid) begin
        if (count_q == LastBit) begin
          count_q <= '0;
          shift_q <= '0;
        end else begin
          count_q <= count_q + 4'd1;
          shift_q <= shifted;
        end
      end

      // Output buffer: a full buffer being drained this edge can accept a new word
      if (word_done) begin
        if ((buf_state_q == StEmpty) || bus.data_ready) begin
          data_q      <= shifted;
          buf_state_q <= StFull;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (transfer) begin
        buf_state_q <= StEmpty;
      end

      if (bus.frame_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = (buf_state_q == StFull);
  assign bus.overrun    = overrun_q;
  assign bus.bit_count  = count_q;

endmodule

// File: tb/tb_serial_to_parallel_reg.sv
// Bench for serial_to_parallel_reg: LSB-first and MSB-first instances share one stimulus stream
// and are compared every cycle against a bit-list reference model.
module tb_serial_to_parallel_reg;

  localparam int W = 8;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  serial_to_parallel_reg_if #(.WIDTH(W)) bus_l ();
  serial_to_parallel_reg_if #(.WIDTH(W)) bus_m ();

  assign bus_m.serial_in   = bus_l.serial_in;
  assign bus_m.bit_valid   = bus_l.bit_valid;
  assign bus_m.frame_clear = bus_l.frame_clear;
  assign bus_m.data_ready  = bus_l.data_ready;

  serial_to_parallel_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_l)
  );

  serial_to_parallel_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_m)
  );

  always #5 clk = ~clk;

  // Reference model: list of bits received in the current frame plus buffer contents
  bit         m_bits[W];
  int         m_cnt;
  logic [7:0] m_data_l;
  logic [7:0] m_data_m;
  bit         m_valid;
  bit         m_ovr;

  task automatic model_reset();
    m_cnt    = 0;
    m_data_l = '0;
    m_data_m = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge(input logic sb, input logic bv, input logic fc, input logic dr);
    bit         xfer;
    logic [7:0] wl;
    logic [7:0] wm;
    xfer = m_valid && dr;
    if (fc) begin
      m_cnt = 0;
      m_ovr = 1'b0;
      if (xfer) m_valid = 1'b0;
    end else if (bv) begin
      m_bits[m_cnt] = sb;
      m_cnt++;
      if (m_cnt == W) begin
        wl = '0;
        wm = '0;
        for (int i = 0; i < W; i++) begin
          wl = wl | (8'(m_bits[i]) << i);
          wm = wm | (8'(m_bits[i]) << (W - 1 - i));
        end
        m_cnt = 0;
        if (!m_valid || dr) begin
          m_data_l = wl;
          m_data_m = wm;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("data_out_lsb", 32'(bus_l.data_out), 32'(m_data_l));
    check("data_out_msb", 32'(bus_m.data_out), 32'(m_data_m));
    check("data_valid_lsb", 32'(bus_l.data_valid), 32'(m_valid));
    check("data_valid_msb", 32'(bus_m.data_valid), 32'(m_valid));
    check("overrun_lsb", 32'(bus_l.overrun), 32'(m_ovr));
    check("overrun_msb", 32'(bus_m.overrun), 32'(m_ovr));
    check("bit_count_lsb", 32'(bus_l.bit_count), 32'(m_cnt));
    check("bit_count_msb", 32'(bus_m.bit_count), 32'(m_cnt));
  endtask

  // One clock: drive inputs away from the edge, advance the model, check after the edge
  task automatic step(input logic sb, input logic bv, input logic fc, input logic dr);
    bus_l.serial_in   = sb;
    bus_l.bit_valid   = bv;
    bus_l.frame_clear = fc;
    bus_l.data_ready  = dr;
    @(posedge clk);
    model_edge(sb, bv, fc, dr);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [7:0] w, input logic dr);
    for (int i = 0; i < W; i++) step(w[i], 1'b1, 1'b0, dr);
  endtask

  initial begin
    logic [7:0] t2;
    resetn            = 1'b0;
    bus_l.serial_in   = 1'b0;
    bus_l.bit_valid   = 1'b0;
    bus_l.frame_clear = 1'b0;
    bus_l.data_ready  = 1'b0;
    model_reset();
    #12;
    check("rst_data_out", 32'(bus_l.data_out), 32'h0);
    check("rst_data_valid", 32'(bus_l.data_valid), 32'h0);
    check("rst_overrun", 32'(bus_l.overrun), 32'h0);
    check("rst_bit_count", 32'(bus_l.bit_count), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 1: A5 LSB-first with the consumer always ready
    send_word(8'hA5, 1'b1);
    check("t1_word", 32'(bus_l.data_out), 32'hA5);
    check("t1_valid_on", 32'(bus_l.data_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_off", 32'(bus_l.data_valid), 32'h0);

    // 2: bits 0,0,1,1,1,1,0,0 with random idle gaps
    t2 = 8'h3C;
    for (int i = 0; i < W; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        step(1'($urandom), 1'b0, 1'b0, 1'b1);
        check("t2_cnt_hold", 32'(bus_m.bit_count), 32'(i));
      end
      step(t2[i], 1'b1, 1'b0, 1'b0);
    end
    check("t2_word_msb", 32'(bus_m.data_out), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: consumer stalled, second word is dropped
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("t3_word", 32'(bus_l.data_out), 32'h11);
    check("t3_ovr", 32'(bus_l.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_drained", 32'(bus_l.data_valid), 32'h0);
    check("t3_ovr_sticky", 32'(bus_l.overrun), 32'h1);

    // 4: new word replaces a buffered one when consumed in the same edge
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h11, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'(8'h22 >> i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("t4_word", 32'(bus_l.data_out), 32'h22);
    check("t4_valid", 32'(bus_l.data_valid), 32'h1);
    check("t4_ovr", 32'(bus_l.overrun), 32'h0);

    // 5: abort a partial frame that coincides with a bit, with overrun set
    send_word(8'h33, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_cnt", 32'(bus_l.bit_count), 32'h0);
    check("t5_ovr", 32'(bus_l.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hFF, 1'b0);
    check("t5_word", 32'(bus_l.data_out), 32'hFF);

    // 6: asynchronous reset mid-frame with a word buffered
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("t6_data_out", 32'(bus_l.data_out), 32'h0);
    check("t6_valid", 32'(bus_l.data_valid), 32'h0);
    check("t6_cnt", 32'(bus_l.bit_count), 32'h0);
    check_all();
    #1;
    resetn = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
